// File: rtl/bcd_updown_counter_pkg.sv
// Shared definitions for the BCD up/down counter.
//   BCD_W        : width of one BCD decade
//   BCD_MAX      : largest legal decade value
//   bcd_sanitize : maps any non-BCD nibble (> 9) to 0, passes legal digits
package cnt_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_MAX) ? digit : '0;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// bcd_digit: one BCD decade cell of the up/down counter.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears q
//   ce    : clock enable (divider tick); nothing changes without it
//   load  : synchronous load (active-high), takes priority over counting
//   d     : load value, sanitised to 0 if > 9
//   up    : direction, 1 = increment, 0 = decrement
//   ci    : carry/borrow in from the lower decade (or count enable for decade 0)
//   q     : current decade value
//   co    : combinational carry/borrow out to the next decade
module bcd_digit
    import cnt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic [BCD_W-1:0] d,
    input  logic             up,
    input  logic             ci,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic at_limit;

    // At 9 when counting up, or at 0 when counting down, the next step wraps.
    assign at_limit = up ? (q == BCD_MAX) : (q == '0);
    assign co       = at_limit & ci;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ce) begin
            if (load) begin
                q <= bcd_sanitize(d);
            end else if (ci) begin
                if (at_limit)
                    q <= up ? '0 : BCD_MAX;
                else
                    q <= up ? q + 4'd1 : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-decade BCD up/down counter advanced by an
// on-board divider tick (one tick every DIV_LEN cycles of CLK_50M).
//   CLK_50M : system clock; all state changes on its rising edge
//   rst_n   : asynchronous active-low reset
//   en      : count enable, sampled on tick cycles
//   load_n  : active-low synchronous load, sampled on tick cycles
//   up_dn   : 1 = count up, 0 = count down
//   din     : parallel BCD load value, digit 0 in [3:0]
//   dout    : current count, digit 0 least significant
//   tc      : terminal count (all 9s counting up, all 0s counting down)
//   cout    : one-cycle pulse after the edge on which the count wraps
//   tick    : divider strobe, one cycle wide
module bcd_updown_counter
    import cnt_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int DIV_LEN = 50_000_000
) (
    input  logic                  CLK_50M,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_n,
    input  logic                  up_dn,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   dout,
    output logic                  tc,
    output logic                  cout,
    output logic                  tick
);

    localparam int               DIV_W    = (DIV_LEN > 1) ? $clog2(DIV_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_LEN - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIGITS:0]  carry;
    logic             all_max;
    logic             all_zero;

    // Divider: tick is registered alongside the wrap, so the tick period is
    // exactly DIV_LEN cycles and the first tick follows the DIV_LEN-th edge.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Decade chain: decade 0 steps on every enabled tick, higher decades step
    // when every lower decade wraps.
    assign carry[0] = en & tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk   (CLK_50M),
            .rst_n (rst_n),
            .ce    (tick),
            .load  (~load_n),
            .d     (din[k*BCD_W +: BCD_W]),
            .up    (up_dn),
            .ci    (carry[k]),
            .q     (dout[k*BCD_W +: BCD_W]),
            .co    (carry[k+1])
        );
    end

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dout[k*BCD_W +: BCD_W] != BCD_MAX) all_max  = 1'b0;
            if (dout[k*BCD_W +: BCD_W] != '0)      all_zero = 1'b0;
        end
    end

    assign tc = up_dn ? all_max : all_zero;

    // The last carry already equals tick & en & tc; a load on that edge
    // replaces the wrap, so it suppresses the pulse.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n)
            cout <= 1'b0;
        else
            cout <= carry[DIGITS] & load_n;
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter (DIGITS = 2, DIV_LEN = 4) plus a
// second single-decade instance (DIV_LEN = 5) for divider spacing.
module tb_bcd_updown_counter;

    logic       CLK_50M = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load_n;
    logic       up_dn;
    logic [7:0] din;
    logic [7:0] dout;
    logic       tc;
    logic       cout;
    logic       tick;

    logic       rst2_n;
    logic [3:0] dout2;
    logic       tc2;
    logic       cout2;
    logic       tick2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK_50M = ~CLK_50M;

    bcd_updown_counter #(.DIGITS(2), .DIV_LEN(4)) dut (
        .CLK_50M (CLK_50M),
        .rst_n   (rst_n),
        .en      (en),
        .load_n  (load_n),
        .up_dn   (up_dn),
        .din     (din),
        .dout    (dout),
        .tc      (tc),
        .cout    (cout),
        .tick    (tick)
    );

    bcd_updown_counter #(.DIGITS(1), .DIV_LEN(5)) dut_div (
        .CLK_50M (CLK_50M),
        .rst_n   (rst2_n),
        .en      (1'b1),
        .load_n  (1'b1),
        .up_dn   (1'b1),
        .din     (4'h0),
        .dout    (dout2),
        .tc      (tc2),
        .cout    (cout2),
        .tick    (tick2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Wait for a tick (sampled on the falling edge), then return on the
    // falling edge right after the update edge.
    task automatic step_tick();
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge CLK_50M);
            if (tick) break;
            n++;
        end
        if (n >= 20) check("tick_timeout", 32'd0, 32'd1);
        @(negedge CLK_50M);
    endtask

    // Count rising edges after reset release until tick is seen.
    task automatic first_tick_edge(output int edge_no);
        edge_no = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK_50M);
            #1;
            if (tick) begin
                edge_no = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int edge_no;
        int n;
        int m;
        int c;
        int last_c;
        int n_ticks;

        rst_n  = 1'b0;
        rst2_n = 1'b0;
        en     = 1'b1;
        load_n = 1'b1;
        up_dn  = 1'b1;
        din    = 8'h00;

        // Reset state
        #12;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_tc_up", 32'(tc), 32'd0);
        up_dn = 1'b0;
        #1;
        check("rst_tc_dn", 32'(tc), 32'd1);
        up_dn = 1'b1;

        @(negedge CLK_50M);
        rst_n = 1'b1;
        first_tick_edge(edge_no);
        check("first_tick_edge", 32'(edge_no), 32'd4);

        // Count up through the full range and wrap
        e = 0;
        for (int i = 0; i < 100; i++) begin
            step_tick();
            e = (e + 1) % 100;
            check("up_dout", 32'(dout), 32'(to_bcd(e)));
            check("up_cout", 32'(cout), 32'(e == 0));
            check("up_tc", 32'(tc), 32'(e == 99));
        end

        // Load 10, count down through 00 to 99
        load_n = 1'b0;
        din    = 8'h10;
        step_tick();
        check("load10_dout", 32'(dout), 32'h10);
        check("load10_cout", 32'(cout), 32'd0);
        load_n = 1'b1;
        up_dn  = 1'b0;
        e = 10;
        for (int i = 0; i < 11; i++) begin
            step_tick();
            e = (e + 99) % 100;
            check("dn_dout", 32'(dout), 32'(to_bcd(e)));
            check("dn_tc", 32'(tc), 32'(e == 0));
            check("dn_cout", 32'(cout), 32'(e == 99));
        end

        // Load priority and sanitising
        en     = 1'b0;
        load_n = 1'b0;
        din    = 8'hA7;
        step_tick();
        check("load_A7", 32'(dout), 32'h07);
        din = 8'h3B;
        step_tick();
        check("load_3B", 32'(dout), 32'h30);
        din = 8'h00;
        step_tick();
        check("load_00", 32'(dout), 32'h00);
        check("load_00_tc", 32'(tc), 32'd1);
        en  = 1'b1;
        din = 8'h35;
        step_tick();
        check("load_tc_dout", 32'(dout), 32'h35);
        check("load_tc_cout", 32'(cout), 32'd0);

        // Hold for 5 ticks, then a direction change between ticks
        din = 8'h42;
        step_tick();
        check("load_42", 32'(dout), 32'h42);
        load_n = 1'b1;
        en     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            check("hold_dout", 32'(dout), 32'h42);
            check("hold_cout", 32'(cout), 32'd0);
        end
        en    = 1'b1;
        up_dn = 1'b1;
        @(negedge CLK_50M);
        up_dn = 1'b0;
        step_tick();
        check("dir_change", 32'(dout), 32'h41);

        // Mid-operation asynchronous reset, asserted while tick is high
        load_n = 1'b0;
        din    = 8'h57;
        step_tick();
        check("load_57", 32'(dout), 32'h57);
        load_n = 1'b1;
        en     = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge CLK_50M);
            if (tick) break;
            n++;
        end
        check("pre_rst_tick", 32'(tick), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout), 32'h00);
        check("async_rst_tick", 32'(tick), 32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        check("async_rst_tc", 32'(tc), 32'd1);
        @(negedge CLK_50M);
        rst_n = 1'b1;
        first_tick_edge(edge_no);
        check("rerst_first_tick", 32'(edge_no), 32'd4);

        // Divider spacing on the DIV_LEN = 5 instance
        @(negedge CLK_50M);
        rst2_n  = 1'b1;
        m       = 0;
        last_c  = 0;
        n_ticks = 0;
        c       = 0;
        while (c < 40 && n_ticks < 4) begin
            @(posedge CLK_50M);
            #1;
            c++;
            if (tick2) begin
                if (n_ticks == 0)
                    check("div_first", 32'(c), 32'd5);
                else
                    check("div_spacing", 32'(c - last_c), 32'd5);
                check("div_dout", 32'(dout2), 32'(m % 10));
                m++;
                last_c = c;
                n_ticks++;
            end
        end
        check("div_ticks_seen", 32'(n_ticks), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
